cbus_arbiter: RTL and testbench
===============================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W 64, address width; DATA_W 64, memory data width; I_DATA_W 32, instruction width.
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have port: ireq_valid  in  1  fetch request pending.
REQ-004 SHALL have port: ireq_addr  in  ADDR_W  fetch address, word aligned.
REQ-005 SHALL have port: iresp_addr_ok  out  1  fetch request accepted.
REQ-006 SHALL have port: iresp_data_ok  out  1  fetch data valid, one-cycle pulse.
REQ-007 SHALL have port: iresp_data  out  I_DATA_W  fetched instruction.
REQ-008 SHALL have ports: dreq_valid  in  1; dreq_addr  in  ADDR_W; dreq_size  in  3  log2 bytes; dreq_strobe  in  8  byte-enables, all zero means load; dreq_data  in  DATA_W  store data.
REQ-009 SHALL have ports: dresp_addr_ok  out  1; dresp_data_ok  out  1  one-cycle pulse; dresp_data  out  DATA_W  load data.
REQ-010 SHALL have ports: mreq_valid  out  1; mreq_is_write  out  1; mreq_addr  out  ADDR_W; mreq_size  out  3; mreq_strobe  out  8; mreq_data  out  DATA_W.
REQ-011 SHALL have ports: mresp_ok  in  1  memory completion pulse; mresp_data  in  DATA_W  read data, valid with mresp_ok.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, TURN.
REQ-013 IDLE: dreq_valid=1 -> BUSY_D; else ireq_valid=1 -> BUSY_I; else stay. Dbus has fixed priority over ibus.
REQ-014 On the IDLE->BUSY_x edge, SHALL latch the granted request (addr, size, strobe, data) into internal registers and pulse the matching *_addr_ok for exactly that cycle.
REQ-015 In BUSY_x, SHALL drive mreq_valid=1 and the mreq_* fields from the latched registers only. Later changes on requester inputs have no effect.
REQ-016 mreq_is_write SHALL be 1 iff the latched strobe is nonzero. Ibus grants use size=3'b010, strobe=0, is_write=0.
REQ-017 In BUSY_x with mresp_ok=1, SHALL pulse the granted *_data_ok in the same cycle (combinational from mresp_ok) and go to TURN.
REQ-018 Response data for ibus: iresp_data = latched addr[2] ? mresp_data[63:32] : mresp_data[31:0].
REQ-019 Response data for dbus: dresp_data = mresp_data unmodified.
REQ-020 TURN SHALL last exactly one cycle with no grant and mreq_valid=0, then go to IDLE, so requesters can update or drop valid.
REQ-021 A requester that drops valid while its transaction is in BUSY_x SHALL NOT abort the memory transaction. The data_ok pulse is still issued, and the requester ignores it.
REQ-022 Outside BUSY_x with mresp_ok=1, mresp_ok SHALL be ignored with no output pulse. A spurious response is not an error.
REQ-023 SHALL keep at most one outstanding memory transaction.
REQ-024 Minimum request-to-data_ok latency SHALL be 2 cycles: grant cycle, then the BUSY cycle with mresp_ok.
REQ-025 Back-to-back requests SHALL complete at most one transaction per 3 cycles plus memory latency.
REQ-026 Outputs not asserted SHALL be driven 0: data buses are 0 outside their data_ok cycle, and mreq_* fields are 0 when mreq_valid=0.

Reset
REQ-027 Reset SHALL force state IDLE, clear latched registers, and drive every output to 0 on the next edge.
REQ-028 Reset asserted mid-transaction (BUSY_x) SHALL abandon the transaction with no data_ok pulse. A mresp_ok arriving after reset is ignored per REQ-022.
REQ-029 With reset held and requests pending, the arbiter SHALL grant nothing. The first grant occurs in the first cycle after reset deasserts.

Verification
REQ-030 Single fetch:
- Stimulus: ireq_valid=1, addr=0x8000_0004; mresp_ok 3 cycles later with data 0x1111_2222_3333_4444.
- Response: iresp_addr_ok in cycle 0; iresp_data_ok in cycle 3 with iresp_data=0x1111_2222; one TURN cycle follows.
REQ-031 Simultaneous requests:
- Stimulus: ireq_valid and dreq_valid both 1 in IDLE.
- Response: dbus granted first; ibus granted in the cycle after TURN; mreq_addr changes only at the grant.
REQ-032 Store:
- Stimulus: dreq strobe=0xF0, data=0xAABB_CCDD_0011_2233, size=2.
- Response: mreq_is_write=1, strobe=0xF0, data held constant while dreq_data toggles during BUSY_D.
REQ-033 Mid-flight reset:
- Stimulus: reset asserted in BUSY_I, then mresp_ok pulses one cycle later.
- Response: no iresp_data_ok; all outputs 0; state IDLE.
REQ-034 Dropped request:
- Stimulus: dreq_valid deasserted after grant.
- Response: mreq_valid stays 1 until mresp_ok; dresp_data_ok pulses once; no extra grant.
REQ-035 Spurious mresp_ok in IDLE or TURN -> no data_ok pulse and no state change.

Source files
------------

// File: rtl/cbus_arbiter.sv
// Two-master arbiter that funnels instruction fetches and data accesses onto a
// single memory port, one outstanding transaction at a time, dbus first.
module cbus_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int I_DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_addr_ok,
  output logic                iresp_data_ok,
  output logic [I_DATA_W-1:0] iresp_data,
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [7:0]          dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                dresp_addr_ok,
  output logic                dresp_data_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                mreq_valid,
  output logic                mreq_is_write,
  output logic [ADDR_W-1:0]   mreq_addr,
  output logic [2:0]          mreq_size,
  output logic [7:0]          mreq_strobe,
  output logic [DATA_W-1:0]   mreq_data,
  input  logic                mresp_ok,
  input  logic [DATA_W-1:0]   mresp_data
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, TURN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_size;
  logic [7:0]          r_strobe;
  logic [DATA_W-1:0]   r_data;

  logic w_grantD;
  logic w_grantI;
  logic w_busy;
  logic w_doneI;
  logic w_doneD;

  // Grants and completions are gated by reset so nothing is accepted or
  // reported while reset is held, even before the state register clears.
  assign w_grantD = (r_state == IDLE) && dreq_valid && !reset;
  assign w_grantI = (r_state == IDLE) && !dreq_valid && ireq_valid && !reset;
  assign w_busy   = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_doneI  = (r_state == BUSY_I) && mresp_ok && !reset;
  assign w_doneD  = (r_state == BUSY_D) && mresp_ok && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_size   <= '0;
      r_strobe <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantD) begin
            r_state  <= BUSY_D;
            r_addr   <= dreq_addr;
            r_size   <= dreq_size;
            r_strobe <= dreq_strobe;
            r_data   <= dreq_data;
          end else if (w_grantI) begin
            r_state  <= BUSY_I;
            r_addr   <= ireq_addr;
            r_size   <= 3'b010;
            r_strobe <= '0;
            r_data   <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mresp_ok) r_state <= TURN;
        end
        TURN:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory side sees only latched fields, and all-zero whenever idle.
  always_comb begin
    mreq_valid    = w_busy;
    mreq_is_write = w_busy && (r_strobe != 8'h00);
    mreq_addr     = w_busy ? r_addr   : '0;
    mreq_size     = w_busy ? r_size   : '0;
    mreq_strobe   = w_busy ? r_strobe : '0;
    mreq_data     = w_busy ? r_data   : '0;
  end

  always_comb begin
    iresp_addr_ok = w_grantI;
    dresp_addr_ok = w_grantD;
    iresp_data_ok = w_doneI;
    dresp_data_ok = w_doneD;
    iresp_data    = '0;
    dresp_data    = '0;
    if (w_doneI)
      iresp_data = r_addr[2] ? mresp_data[2*I_DATA_W-1:I_DATA_W] : mresp_data[I_DATA_W-1:0];
    if (w_doneD)
      dresp_data = mresp_data;
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: stimulus pushes expected responses into a
// queue that an independent negedge monitor pops whenever a data_ok fires.
module tb_cbus_arbiter;

  typedef struct {
    logic        isD;
    logic [63:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic        mreq_is_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_ok;
  logic [63:0] mresp_data;

  resp_t expQ[$];
  int    checks   = 0;
  int    failures = 0;

  cbus_arbiter #(.ADDR_W(64), .DATA_W(64), .I_DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_is_write(mreq_is_write), .mreq_addr(mreq_addr),
    .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_ok(mresp_ok), .mresp_data(mresp_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the memory response for the current cycle and records what the
  // requester should see if the response lands on a live transaction.
  task automatic applyStimulus(input logic ok, input logic [63:0] data,
                               input logic push, input logic isD, input logic [63:0] expData);
    resp_t r;
    mresp_ok   = ok;
    mresp_data = data;
    if (push) begin
      r.isD  = isD;
      r.data = expData;
      expQ.push_back(r);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every data_ok pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (iresp_data_ok || dresp_data_ok) begin
      resp_t e;
      checks++;
      if (iresp_data_ok && dresp_data_ok) begin
        failures++;
        $display("[TB] FAIL both_data_ok: got i=1 d=1, expected a single pulse");
      end else if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_data_ok: got i=%0b d=%0b, expected none", iresp_data_ok, dresp_data_ok);
      end else begin
        logic [63:0] act;
        e   = expQ.pop_front();
        act = dresp_data_ok ? dresp_data : {32'h0, iresp_data};
        if (dresp_data_ok !== e.isD || act !== e.data) begin
          failures++;
          $display("[TB] FAIL resp_data: got isD=%0b data=0x%0h, expected isD=%0b data=0x%0h",
                   dresp_data_ok, act, e.isD, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);

    // Requests pending under reset must not be granted.
    sample();
    checkOutput("rst_iaddr_ok", {63'h0, iresp_addr_ok}, 64'h0);
    nextCycle();
    sample();
    checkOutput("rst_iaddr_ok2", {63'h0, iresp_addr_ok}, 64'h0);
    checkOutput("rst_mreq_valid", {63'h0, mreq_valid}, 64'h0);
    checkOutput("rst_mreq_addr", mreq_addr, 64'h0);

    // Single fetch, upper word selected by addr[2]; memory answers 3 cycles later.
    nextCycle();
    reset = 1'b0;
    sample();
    checkOutput("fetch_addr_ok", {63'h0, iresp_addr_ok}, 64'h1);
    checkOutput("fetch_idle_mreq_valid", {63'h0, mreq_valid}, 64'h0);
    nextCycle();
    ireq_valid = 1'b0;
    sample();
    checkOutput("fetch_mreq_valid", {63'h0, mreq_valid}, 64'h1);
    checkOutput("fetch_mreq_addr", mreq_addr, 64'h8000_0004);
    checkOutput("fetch_mreq_size", {61'h0, mreq_size}, 64'h2);
    checkOutput("fetch_is_write", {63'h0, mreq_is_write}, 64'h0);
    checkOutput("fetch_addr_ok_pulse", {63'h0, iresp_addr_ok}, 64'h0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 64'h1111_2222);
    nextCycle();
    // Spurious response during TURN.
    applyStimulus(1'b1, 64'h9999_9999_9999_9999, 1'b0, 1'b0, 64'h0);
    sample();
    checkOutput("turn_mreq_valid", {63'h0, mreq_valid}, 64'h0);
    checkOutput("turn_iresp_data", {32'h0, iresp_data}, 64'h0);
    checkOutput("turn_data_ok", {62'h0, iresp_data_ok, dresp_data_ok}, 64'h0);
    nextCycle();
    // Spurious response in IDLE.
    sample();
    checkOutput("idle_spur_data_ok", {62'h0, iresp_data_ok, dresp_data_ok}, 64'h0);
    checkOutput("idle_spur_dresp_data", dresp_data, 64'h0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    sample();
    checkOutput("idle_spur_no_state", {63'h0, mreq_valid}, 64'h0);

    // Simultaneous requests: dbus first, ibus after TURN.
    nextCycle();
    ireq_valid = 1'b1; ireq_addr = 64'h100;
    dreq_valid = 1'b1; dreq_addr = 64'h200; dreq_size = 3'd3; dreq_strobe = 8'h00;
    sample();
    checkOutput("sim_daddr_ok", {63'h0, dresp_addr_ok}, 64'h1);
    checkOutput("sim_iaddr_ok", {63'h0, iresp_addr_ok}, 64'h0);
    nextCycle();
    dreq_valid = 1'b0;
    applyStimulus(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567);
    sample();
    checkOutput("sim_d_mreq_addr", mreq_addr, 64'h200);
    checkOutput("sim_d_size", {61'h0, mreq_size}, 64'h3);
    checkOutput("sim_busy_iaddr_ok", {63'h0, iresp_addr_ok}, 64'h0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    sample();
    checkOutput("sim_turn_iaddr_ok", {63'h0, iresp_addr_ok}, 64'h0);
    checkOutput("sim_turn_mreq_addr", mreq_addr, 64'h0);
    nextCycle();
    sample();
    checkOutput("sim_i_grant", {63'h0, iresp_addr_ok}, 64'h1);
    nextCycle();
    ireq_valid = 1'b0;
    applyStimulus(1'b1, 64'hCAFE_F00D_8765_4321, 1'b1, 1'b0, 64'h8765_4321);
    sample();
    checkOutput("sim_i_mreq_addr", mreq_addr, 64'h100);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();

    // Store: latched fields hold while requester inputs churn.
    dreq_valid = 1'b1; dreq_addr = 64'h3000; dreq_size = 3'd2;
    dreq_strobe = 8'hF0; dreq_data = 64'hAABB_CCDD_0011_2233;
    sample();
    checkOutput("st_addr_ok", {63'h0, dresp_addr_ok}, 64'h1);
    nextCycle();
    dreq_valid = 1'b0; dreq_data = ~dreq_data; dreq_strobe = 8'h0F; dreq_addr = 64'h4000;
    sample();
    checkOutput("st_is_write", {63'h0, mreq_is_write}, 64'h1);
    checkOutput("st_strobe", {56'h0, mreq_strobe}, 64'hF0);
    checkOutput("st_data", mreq_data, 64'hAABB_CCDD_0011_2233);
    checkOutput("st_addr", mreq_addr, 64'h3000);
    nextCycle();
    dreq_data = ~dreq_data;
    sample();
    checkOutput("st_data_hold", mreq_data, 64'hAABB_CCDD_0011_2233);
    nextCycle();
    applyStimulus(1'b1, 64'h5555_0000_5555_0000, 1'b1, 1'b1, 64'h5555_0000_5555_0000);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();

    // Dropped request: transaction still completes, no regrant.
    dreq_valid = 1'b1; dreq_addr = 64'h40; dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_data = '0;
    nextCycle();
    dreq_valid = 1'b0;
    sample();
    checkOutput("drop_mreq_valid1", {63'h0, mreq_valid}, 64'h1);
    nextCycle();
    sample();
    checkOutput("drop_mreq_valid2", {63'h0, mreq_valid}, 64'h1);
    nextCycle();
    applyStimulus(1'b1, 64'h0BAD_F00D_0000_0001, 1'b1, 1'b1, 64'h0BAD_F00D_0000_0001);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    sample();
    checkOutput("drop_turn_valid", {63'h0, mreq_valid}, 64'h0);
    nextCycle();
    sample();
    checkOutput("drop_no_regrant", {62'h0, iresp_addr_ok, dresp_addr_ok}, 64'h0);
    nextCycle();
    sample();
    checkOutput("drop_idle_valid", {63'h0, mreq_valid}, 64'h0);

    // Mid-flight reset in BUSY_I, late response must be ignored.
    nextCycle();
    ireq_valid = 1'b1; ireq_addr = 64'h8;
    nextCycle();
    ireq_valid = 1'b0;
    sample();
    checkOutput("mr_busy", {63'h0, mreq_valid}, 64'h1);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0);
    sample();
    checkOutput("mr_data_ok", {63'h0, iresp_data_ok}, 64'h0);
    checkOutput("mr_iresp_data", {32'h0, iresp_data}, 64'h0);
    checkOutput("mr_mreq_valid", {63'h0, mreq_valid}, 64'h0);
    checkOutput("mr_mreq_addr", mreq_addr, 64'h0);
    nextCycle();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    sample();
    checkOutput("mr_idle", {63'h0, mreq_valid}, 64'h0);

    nextCycle();
    nextCycle();
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
